// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the polyphonic tone synthesiser
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   localparam int AMP_MAX_DEF   = 10000000;
   localparam int RAMP_STEP_DEF = 16;

   // Half-period in CLOCK_50 cycles, 50_000_000 / (2 * f), notes A4..G5
   localparam int HP_A = 56818;
   localparam int HP_B = 50619;
   localparam int HP_C = 47778;
   localparam int HP_D = 42565;
   localparam int HP_E = 37921;
   localparam int HP_F = 35793;
   localparam int HP_G = 31888;

endpackage

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one square-wave oscillator with linear attack/release envelope
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   on_i, off_i      validated note-on / note-off strobes for this voice
//   half_period_i    cycles per half wave, captured on on_i
//   amp_o, phase_o   envelope amplitude and square-wave polarity
//   active_o         voice is not IDLE
module tone_voice
   import synth_pkg::*;
#(
   parameter int DIV_W     = 23,
   parameter int AMP_W     = 24,
   parameter int AMP_MAX   = AMP_MAX_DEF,
   parameter int RAMP_STEP = RAMP_STEP_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             on_i,
   input  logic             off_i,
   input  logic [DIV_W-1:0] half_period_i,
   output logic [AMP_W-1:0] amp_o,
   output logic             phase_o,
   output logic             active_o
);

   localparam logic [AMP_W-1:0] MAX_V  = AMP_W'(AMP_MAX);
   localparam logic [AMP_W-1:0] STEP_V = AMP_W'(RAMP_STEP);
   localparam logic [DIV_W-1:0] ONE_D  = DIV_W'(1);

   env_state_t       state_q, state_d;
   logic [AMP_W-1:0] amp_q, amp_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic             phase_q, phase_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         amp_q    <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         phase_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         amp_q    <= amp_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         phase_q  <= phase_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      amp_d    = amp_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      phase_d  = phase_q;

      // >= rather than == so a retune to a shorter period never overruns
      if (state_q != IDLE) begin
         if (cnt_q >= period_q - ONE_D) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + ONE_D;
         end
      end else begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (on_i) begin
               state_d  = ATTACK;
               period_d = half_period_i;
            end
         end
         ATTACK: begin
            if (on_i) begin
               period_d = half_period_i;
            end
            if (off_i && !on_i) begin
               state_d = RELEASE;
            end else if (amp_q >= MAX_V - STEP_V) begin
               amp_d   = MAX_V;
               state_d = SUSTAIN;
            end else begin
               amp_d = amp_q + STEP_V;
            end
         end
         SUSTAIN: begin
            if (on_i) begin
               period_d = half_period_i;
            end else if (off_i) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // re-attack keeps the current amplitude and oscillator phase
            if (on_i) begin
               state_d  = ATTACK;
               period_d = half_period_i;
            end else if (amp_q <= STEP_V) begin
               amp_d   = '0;
               state_d = IDLE;
               cnt_d   = '0;
               phase_d = 1'b0;
            end else begin
               amp_d = amp_q - STEP_V;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign amp_o    = amp_q;
   assign phase_o  = phase_q;
   assign active_o = (state_q != IDLE);

endmodule

// File: rtl/poly_tone_synth.sv
// rtl/poly_tone_synth.sv - polyphonic square-wave synth with saturating mixer and valid/ready output
// Ports:
//   CLOCK_50, reset              clock, synchronous active-high reset
//   note_on_en, note_off_en      one-cycle command strobes for voice voice_idx
//   voice_idx, half_period       target voice and half-period (sampled on note_on_en)
//   sample_ready                 sink accepts the current sample
//   sample_out, sample_valid     signed mixed sample and its valid flag
//   voice_active                 bit i set while voice i is not IDLE
//   clipped                      sticky saturation flag
module poly_tone_synth
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 7,
   parameter int DIV_W      = 23,
   parameter int AMP_W      = 24,
   parameter int AMP_MAX    = AMP_MAX_DEF,
   parameter int RAMP_STEP  = RAMP_STEP_DEF,
   parameter int OUT_W      = 32,
   localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  note_on_en,
   input  logic                  note_off_en,
   input  logic [IDX_W-1:0]      voice_idx,
   input  logic [DIV_W-1:0]      half_period,
   input  logic                  sample_ready,
   output logic [OUT_W-1:0]      sample_out,
   output logic                  sample_valid,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  clipped
);

   localparam int SUM_W = AMP_W + 1 + $clog2(NUM_VOICES);
   // one bit wider than both sum and output so the limit compare is exact either way
   localparam int CMP_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
   localparam logic signed [CMP_W-1:0] LIM_HI =
      signed'({{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [CMP_W-1:0] LIM_LO = -LIM_HI;

   logic idx_ok, hp_ok, on_cmd, off_cmd;

   assign idx_ok  = ({1'b0, voice_idx} < (IDX_W+1)'(NUM_VOICES));
   assign hp_ok   = (half_period >= DIV_W'(2));
   assign on_cmd  = note_on_en && idx_ok && hp_ok;
   assign off_cmd = note_off_en && idx_ok && !on_cmd;

   logic [AMP_W-1:0]      amp_w [NUM_VOICES];
   logic [NUM_VOICES-1:0] phase_w;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic sel;
      assign sel = (voice_idx == IDX_W'(gi));
      tone_voice #(
         .DIV_W     (DIV_W),
         .AMP_W     (AMP_W),
         .AMP_MAX   (AMP_MAX),
         .RAMP_STEP (RAMP_STEP)
      ) u_voice (
         .clk_i         (CLOCK_50),
         .rst_i         (reset),
         .on_i          (on_cmd && sel),
         .off_i         (off_cmd && sel),
         .half_period_i (half_period),
         .amp_o         (amp_w[gi]),
         .phase_o       (phase_w[gi]),
         .active_o      (voice_active[gi])
      );
   end

   function automatic logic signed [SUM_W-1:0] contrib(input logic [AMP_W-1:0] a,
                                                       input logic ph);
      logic signed [SUM_W-1:0] m;
      m = signed'({{(SUM_W-AMP_W){1'b0}}, a});
      return ph ? m : -m;
   endfunction

   logic signed [SUM_W-1:0] sum;
   logic signed [CMP_W-1:0] sum_x;
   logic                    sat_hi, sat_lo;
   logic [OUT_W-1:0]        mix_d;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         sum = sum + contrib(amp_w[i], phase_w[i]);
      end
   end

   assign sum_x = {{(CMP_W-SUM_W){sum[SUM_W-1]}}, sum};

   always_comb begin
      sat_hi = (sum_x > LIM_HI);
      sat_lo = (sum_x < LIM_LO);
      mix_d  = sum_x[OUT_W-1:0];
      if (sat_hi) begin
         mix_d = LIM_HI[OUT_W-1:0];
      end else if (sat_lo) begin
         mix_d = LIM_LO[OUT_W-1:0];
      end
   end

   logic [OUT_W-1:0] next_q, sample_q;
   logic             next_valid_q, valid_q, clipped_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         next_q       <= '0;
         next_valid_q <= 1'b0;
         sample_q     <= '0;
         valid_q      <= 1'b0;
         clipped_q    <= 1'b0;
      end else begin
         next_q       <= mix_d;
         next_valid_q <= 1'b1;
         if (sat_hi || sat_lo) begin
            clipped_q <= 1'b1;
         end
         if (!valid_q || sample_ready) begin
            sample_q <= next_q;
            valid_q  <= next_valid_q;
         end
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign clipped      = clipped_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// tb/tb_poly_tone_synth.sv - directed scoreboard bench for poly_tone_synth
module tb_poly_tone_synth;

   localparam int NV   = 7;
   localparam int DW   = 12;
   localparam int AW   = 12;
   localparam int AMAX = 1600;
   localparam int STEP = 16;
   localparam int OW   = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          on_en = 1'b0;
   logic          off_en = 1'b0;
   logic          ready = 1'b1;
   logic [2:0]    idx = '0;
   logic [DW-1:0] hp = '0;
   logic [OW-1:0] sample_out;
   logic          sample_valid;
   logic [NV-1:0] voice_active;
   logic          clipped;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   poly_tone_synth #(
      .NUM_VOICES (NV),
      .DIV_W      (DW),
      .AMP_W      (AW),
      .AMP_MAX    (AMAX),
      .RAMP_STEP  (STEP),
      .OUT_W      (OW)
   ) dut (
      .CLOCK_50     (clk),
      .reset        (rst),
      .note_on_en   (on_en),
      .note_off_en  (off_en),
      .voice_idx    (idx),
      .half_period  (hp),
      .sample_ready (ready),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .voice_active (voice_active),
      .clipped      (clipped)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input string tag, input int v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input int obs);
      string tag;
      int    e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      end else begin
         tag = tag_q.pop_front();
         e   = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
         end
      end
   endtask

   task automatic check_now(input string tag, input int obs, input int e);
      push(tag, e);
      pop_check(obs);
   endtask

   task automatic note_on(input int v, input int h);
      idx   = 3'(v);
      hp    = DW'(h);
      on_en = 1'b1;
      tick();
      on_en = 1'b0;
   endtask

   task automatic note_off(input int v);
      idx    = 3'(v);
      off_en = 1'b1;
      tick();
      off_en = 1'b0;
   endtask

   function automatic int sgn(input int j, input int h);
      return (((j / h) % 2) != 0) ? 1 : -1;
   endfunction

   function automatic int s_val();
      return int'($signed(sample_out));
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int j, a, r, tA, tB, tC, tD, tE, tF, tG;

      // reset state
      repeat (3) tick();
      check_now("rst_sample", s_val(), 0);
      check_now("rst_valid", int'(sample_valid), 0);
      check_now("rst_active", int'(voice_active), 0);
      check_now("rst_clipped", int'(clipped), 0);
      rst = 1'b0;
      tick();
      check_now("valid_after_1", int'(sample_valid), 0);
      tick();
      check_now("valid_after_2", int'(sample_valid), 1);
      check_now("idle_sample", s_val(), 0);

      // 1: attack on voice 0, half-period 20
      note_on(0, 20);
      tA = cyc;
      check_now("t1_active", int'(voice_active), 1);
      for (int k = 1; k <= 128; k++) begin
         j = k - 2;
         a = (j <= 0) ? 0 : ((STEP * j > AMAX) ? AMAX : STEP * j);
         push("t1_attack", (j < 0) ? 0 : sgn(j, 20) * a);
      end
      for (int k = 1; k <= 128; k++) begin
         tick();
         pop_check(s_val());
      end
      check_now("t1_active_sus", int'(voice_active), 1);
      check_now("t1_clipped", int'(clipped), 0);

      // 2: release voice 0 to idle
      note_off(0);
      tB = cyc;
      for (int k = 1; k <= 104; k++) begin
         r = k - 2;
         a = (r <= 0) ? AMAX : ((AMAX - STEP * r < 0) ? 0 : AMAX - STEP * r);
         push("t2_release", sgn((tB - tA) + r, 20) * a);
      end
      for (int k = 1; k <= 104; k++) begin
         tick();
         pop_check(s_val());
      end
      check_now("t2_idle_active", int'(voice_active), 0);

      // 3: release voice 2 halfway then re-attack from current amplitude
      note_on(2, 30);
      tC = cyc;
      repeat (105) tick();
      note_off(2);
      tD = cyc;
      repeat (49) tick();
      note_on(2, 30);
      tE = cyc;
      check_now("t3_active", int'(voice_active), 4);
      for (int k = 1; k <= 60; k++) begin
         r = k - 2;
         a = (r <= 0) ? 816 : ((816 + STEP * r > AMAX) ? AMAX : 816 + STEP * r);
         push("t3_reattack_mag", a);
      end
      for (int k = 1; k <= 60; k++) begin
         tick();
         pop_check(iabs(s_val()));
      end

      // 5: back-pressure holds the sample; release loads the next one a clock later
      tF = cyc;
      ready = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         push("t5_hold", sgn(tF - 2 - tC, 30) * AMAX);
      end
      for (int k = 1; k <= 50; k++) begin
         tick();
         pop_check(s_val());
      end
      check_now("t5_valid_held", int'(sample_valid), 1);
      ready = 1'b1;
      push("t5_resume_1", sgn(tF + 49 - tC, 30) * AMAX);
      push("t5_resume_2", sgn(tF + 50 - tC, 30) * AMAX);
      tick();
      pop_check(s_val());
      tick();
      pop_check(s_val());

      // 6: command edge cases, then reset mid-attack
      idx    = 3'd3;
      hp     = DW'(50);
      on_en  = 1'b1;
      off_en = 1'b1;
      tick();
      on_en  = 1'b0;
      off_en = 1'b0;
      tick();
      check_now("t6_on_wins", int'(voice_active), 12);
      note_on(7, 50);
      tick();
      check_now("t6_idx7", int'(voice_active), 12);
      note_on(4, 1);
      tick();
      check_now("t6_hp1", int'(voice_active), 12);
      rst = 1'b1;
      tick();
      check_now("t6_rst_sample", s_val(), 0);
      check_now("t6_rst_valid", int'(sample_valid), 0);
      check_now("t6_rst_active", int'(voice_active), 0);
      check_now("t6_rst_clipped", int'(clipped), 0);
      rst = 1'b0;
      tick();
      tick();
      check_now("t6_valid_again", int'(sample_valid), 1);

      // 4: five voices in phase stay in range, seven voices saturate
      note_on(0, 1000);
      tG = cyc;
      for (int v = 1; v <= 4; v++) note_on(v, 1000);
      repeat (110) tick();
      check_now("t4_five_sum", s_val(), -5 * AMAX);
      check_now("t4_five_noclip", int'(clipped), 0);
      note_on(5, 1000);
      note_on(6, 1000);
      repeat (110) tick();
      check_now("t4_seven_sat", s_val(), -8191);
      check_now("t4_clipped", int'(clipped), 1);
      check_now("t4_all_active", int'(voice_active), 127);
      check_now("t4_elapsed", cyc - tG, 226);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
